// File: rtl/spi_byte_sequencer_if.sv
// Handshake bundle between the byte sequencer and its environment (run control,
// SPI master start/done hand-off, and the run status outputs).
interface spi_byte_sequencer_if;
    logic       go;
    logic       spi_done;
    logic [7:0] spi_rx_data;
    logic       spi_start;
    logic [7:0] spi_tx_data;
    logic       busy;
    logic [7:0] byte_cnt;
    logic [7:0] err_cnt;
    logic       timeout;
    logic       run_done;
    logic       pass;
    logic       fail;

    // Sequencer side: drives the SPI master start/data and reports status.
    modport master (
        input  go, spi_done, spi_rx_data,
        output spi_start, spi_tx_data, busy, byte_cnt, err_cnt,
               timeout, run_done, pass, fail
    );

    // Environment side: requests runs and answers transfers.
    modport slave (
        output go, spi_done, spi_rx_data,
        input  spi_start, spi_tx_data, busy, byte_cnt, err_cnt,
               timeout, run_done, pass, fail
    );
endinterface

// File: rtl/spi_byte_sequencer.sv
// Burst controller for the SPI master: issues NUM_BYTES counted transfers with an
// idle gap, checks each received byte and produces a watchdog-protected verdict.
module spi_byte_sequencer #(
    parameter int         NUM_BYTES  = 4,
    parameter logic [7:0] EXP_DATA   = 8'h3C,
    parameter logic [7:0] TX_BASE    = 8'hA5,
    parameter int         GAP_CYCLES = 2,
    parameter int         TIMEOUT    = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_byte_sequencer_if.master bus
);
    localparam int              WD_W     = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [7:0]      IDX_LAST = 8'(NUM_BYTES - 1);
    localparam logic [7:0]      GAP_LAST = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_GAP,
        S_FINISH
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [7:0]      r_idx;
    logic [7:0]      r_gap;
    logic [WD_W-1:0] r_wd;
    logic            r_spi_start;
    logic [7:0]      r_tx_data;
    logic            r_busy;
    logic [7:0]      r_byte_cnt;
    logic [7:0]      r_err_cnt;
    logic            r_timeout;
    logic            r_run_done;
    logic            r_pass;
    logic            r_fail;

    logic [7:0]      w_idx_nxt;
    logic [7:0]      w_gap_nxt;
    logic [WD_W-1:0] w_wd_nxt;
    logic [7:0]      w_tx_nxt;
    logic [7:0]      w_byte_nxt;
    logic [7:0]      w_err_nxt;
    logic            w_to_nxt;
    logic            w_pass_nxt;
    logic            w_fail_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_gap_nxt   = r_gap;
        w_wd_nxt    = r_wd;
        w_tx_nxt    = r_tx_data;
        w_byte_nxt  = r_byte_cnt;
        w_err_nxt   = r_err_cnt;
        w_to_nxt    = r_timeout;
        w_pass_nxt  = r_pass;
        w_fail_nxt  = r_fail;

        case (r_state)
            S_IDLE: begin
                if (bus.go) begin
                    w_idx_nxt   = 8'd0;
                    w_byte_nxt  = 8'd0;
                    w_err_nxt   = 8'd0;
                    w_to_nxt    = 1'b0;
                    w_pass_nxt  = 1'b0;
                    w_fail_nxt  = 1'b0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_wd_nxt    = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (bus.spi_done) begin
                    w_byte_nxt = r_byte_cnt + 8'd1;
                    if ((bus.spi_rx_data != EXP_DATA) && (r_err_cnt != 8'hFF)) begin
                        w_err_nxt = r_err_cnt + 8'd1;
                    end
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = S_FINISH;
                    end else if (GAP_CYCLES == 0) begin
                        w_idx_nxt   = r_idx + 8'd1;
                        w_state_nxt = S_START;
                    end else begin
                        w_gap_nxt   = 8'd0;
                        w_state_nxt = S_GAP;
                    end
                end else if (r_wd == WD_LAST) begin
                    // Watchdog expiry: the WAIT state has lasted TIMEOUT cycles.
                    w_to_nxt    = 1'b1;
                    w_state_nxt = S_FINISH;
                end else begin
                    w_wd_nxt = r_wd + WD_W'(1);
                end
            end
            S_GAP: begin
                if (r_gap == GAP_LAST) begin
                    w_idx_nxt   = r_idx + 8'd1;
                    w_state_nxt = S_START;
                end else begin
                    w_gap_nxt = r_gap + 8'd1;
                end
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Verdict uses the counts as updated by the final transfer or the watchdog.
        if (w_state_nxt == S_FINISH) begin
            w_pass_nxt = (w_err_nxt == 8'd0) && !w_to_nxt;
            w_fail_nxt = !((w_err_nxt == 8'd0) && !w_to_nxt);
        end

        if (w_state_nxt == S_START) begin
            w_tx_nxt = TX_BASE + w_idx_nxt;
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx       <= 8'd0;
            r_gap       <= 8'd0;
            r_wd        <= '0;
            r_spi_start <= 1'b0;
            r_tx_data   <= 8'd0;
            r_busy      <= 1'b0;
            r_byte_cnt  <= 8'd0;
            r_err_cnt   <= 8'd0;
            r_timeout   <= 1'b0;
            r_run_done  <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_idx       <= w_idx_nxt;
            r_gap       <= w_gap_nxt;
            r_wd        <= w_wd_nxt;
            r_spi_start <= (w_state_nxt == S_START);
            r_tx_data   <= w_tx_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_byte_cnt  <= w_byte_nxt;
            r_err_cnt   <= w_err_nxt;
            r_timeout   <= w_to_nxt;
            r_run_done  <= (w_state_nxt == S_FINISH);
            r_pass      <= w_pass_nxt;
            r_fail      <= w_fail_nxt;
        end
    end

    assign bus.spi_start   = r_spi_start;
    assign bus.spi_tx_data = r_tx_data;
    assign bus.busy        = r_busy;
    assign bus.byte_cnt    = r_byte_cnt;
    assign bus.err_cnt     = r_err_cnt;
    assign bus.timeout     = r_timeout;
    assign bus.run_done    = r_run_done;
    assign bus.pass        = r_pass;
    assign bus.fail        = r_fail;
endmodule

// File: doc/spi_byte_sequencer.md
# spi_byte_sequencer

Upstream control stage for the SPI master. Runs a burst of `NUM_BYTES` single-byte SPI transfers back-to-back with a programmable idle gap. For each transfer it generates the master's start pulse and transmit byte, then captures and checks the returned receive byte against a fixed expected value. It replaces the one-shot start/compare logic in the top level with a counted, watchdog-protected burst and a sticky pass/fail verdict.

## Interface
- `NUM_BYTES`, 4: transfers per run; legal range 1..255.
- `EXP_DATA`, 8'h3C: expected `spi_rx_data` for every transfer.
- `TX_BASE`, 8'hA5: transmit byte for transfer 0; transfer i sends `TX_BASE + i` (mod 256).
- `GAP_CYCLES`, 2: idle cycles between a transfer's `spi_done` and the next `spi_start`; legal range 0..255.
- `TIMEOUT`, 1024: maximum number of WAIT cycles allowed per transfer before the run is aborted; must be ≥2.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `go`  in  1  one-cycle run request; sampled only in IDLE.
- `spi_done`  in  1  one-cycle transfer-complete pulse from the master.
- `spi_rx_data`  in  8  received byte; valid in the cycle `spi_done` is high.
- `spi_start`  out  1  one-cycle start pulse to the master.
- `spi_tx_data`  out  8  transmit byte; held stable from `spi_start` until `spi_done`.
- `busy`  out  1  high in every state except IDLE.
- `byte_cnt`  out  8  number of transfers completed in the current or last run.
- `err_cnt`  out  8  number of mismatched transfers; saturates at 255.
- `timeout`  out  1  sticky flag: the last run was aborted by the watchdog.
- `run_done`  out  1  one-cycle pulse at the end of a run.
- `pass`, `fail`  out  1 each  verdict of the last run; both held until the next accepted `go`.

## Operation
- States: IDLE, START, WAIT, GAP, FINISH.
- **IDLE**
  - When `go`=1: clear `byte_cnt`, `err_cnt`, `timeout`, `pass`, `fail`, and the byte index; go to START.
- **START**
  - Assert `spi_start` for one cycle.
  - Drive `spi_tx_data` = `TX_BASE` + index.
  - Clear the watchdog counter; go to WAIT.
- **WAIT**
  - On `spi_done`:
    - Increment `byte_cnt`.
    - If `spi_rx_data` ≠ `EXP_DATA`, increment `err_cnt` (saturating at 255).
    - If index = `NUM_BYTES`−1, go to FINISH.
    - Otherwise, if `GAP_CYCLES`=0, increment the index and go to START; if `GAP_CYCLES`>0, go to GAP.
  - Otherwise, increment the watchdog counter. When it reaches `TIMEOUT`−1, set `timeout` and go to FINISH.
- **GAP**
  - Count `GAP_CYCLES` cycles, then increment the index and go to START.
- **FINISH**
  - Pulse `run_done` for one cycle.
  - `pass` = (`err_cnt`==0 && !`timeout`); `fail` = !`pass`.
  - Go to IDLE.
- **Ignored inputs**
  - `go` outside IDLE is ignored.
  - `spi_done` outside WAIT is ignored and does not change any counter.
- **Final transfer**
  - The mismatch on the final transfer is included in the verdict, because the FINISH comparison uses the updated `err_cnt`.
- **Reset (`rst`=0)**
  - Asserting reset at any time, including mid-run, forces IDLE immediately.
  - All outputs go to 0, including `spi_start` and `spi_tx_data`.
  - There is no partial verdict after reset.

## Timing
- All outputs are registered.
- `go` sampled at edge k → `busy` and `spi_start` are high in the cycle after edge k.
- `spi_tx_data` is valid in the same cycle as `spi_start`.
- `spi_done` sampled at edge k (not the last transfer) → next `spi_start` is high `GAP_CYCLES`+1 cycles later.
- `byte_cnt` and `err_cnt` update on the edge that samples `spi_done`.
- Last `spi_done` sampled at edge k → `run_done`, `pass`, and `fail` change one cycle later; `busy` falls in the cycle after `run_done`.
- Timeout: `run_done` follows `TIMEOUT`+1 cycles after `spi_start`, with no `spi_done` received in between.
- A `go` arriving in the cycle `busy` falls is accepted.

## Test plan
- **Clean run:** `NUM_BYTES`=4, `GAP_CYCLES`=2, model returns 8'h3C every transfer.
  - `spi_tx_data` sequence is A5, A6, A7, A8.
  - `byte_cnt`=4, `err_cnt`=0, `pass`=1, `fail`=0, exactly one `run_done` pulse.
- **Mismatch on last transfer:** model returns 8'h3C, 8'h3C, 8'h3C, 8'h3D.
  - `err_cnt`=1, `fail`=1, `pass`=0.
- **Watchdog:** `TIMEOUT`=16, model never pulses `spi_done`.
  - `timeout`=1, `fail`=1, `byte_cnt`=0.
  - `run_done` follows `spi_start` by 17 cycles.
- **Zero gap, index wrap:** `GAP_CYCLES`=0, `TX_BASE`=8'hFE, `NUM_BYTES`=3.
  - `spi_tx_data` sequence is FE, FF, 00.
  - Each `spi_start` comes 1 cycle after the previous `spi_done`.
- **Stray inputs:** pulse `go` while busy and `spi_done` while in GAP.
  - No second run starts and no counter changes.
- **Reset mid-run:** drop `rst` during the second WAIT.
  - All outputs go to 0 immediately.
  - After reset is released, a new `go` produces a clean 4-transfer pass.
